sipo_nbit_rx: RTL



---
 rtl/sipo_nbit_rx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sipo_nbit_rx.sv
// sipo_nbit_rx: deserializing end of the LSB-first serial link.
// Collects N qualified serial bits, hands each completed word to a holding
// register with a valid/ready handshake, and flags words that are lost
// while the consumer stalls.
module sipo_nbit_rx #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset_al_in,
  input  logic                 sd_in,
  input  logic                 sd_valid_in,
  input  logic                 sync_in,
  input  logic                 data_ready_in,
  input  logic                 overrun_clr_in,
  output logic [N-1:0]         data_out,
  output logic                 data_valid_out,
  output logic                 overrun_out,
  output logic [$clog2(N)-1:0] bit_cnt_out
);

  localparam int             CW       = $clog2(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

  // Frame assembly state
  logic [N-1:0]  r_shift;
  logic [CW-1:0] r_cnt;

  // Output holding state
  logic [N-1:0]  r_data;
  logic          r_valid;
  logic          r_overrun;

  // Per-edge decode of the serial and handshake inputs
  logic          w_sample;
  logic          w_sync;
  logic          w_complete;
  logic          w_consume;
  logic          w_load;
  logic          w_drop;
  logic [N-1:0]  w_word;

  // Decode which events happen on the coming edge.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_sample   = 1'b0;
    w_sync     = 1'b0;
    w_complete = 1'b0;
    w_consume  = 1'b0;
    w_load     = 1'b0;
    w_drop     = 1'b0;
    w_word     = {sd_in, r_shift[N-1:1]};

    w_sample = sd_valid_in;
    // Sync only counts when the bit it marks is actually sampled.
    w_sync   = sd_valid_in & sync_in;
    // A sync on the last-bit position starts a new frame instead of
    // completing the old one.
    w_complete = w_sample & ~w_sync & (r_cnt == CNT_LAST);

    // Ready is meaningful only while a word is being offered.
    w_consume = r_valid & data_ready_in;

    // Load when the holding register is free or frees up on this same edge;
    // otherwise the completed word has nowhere to go and is dropped.
    w_load = w_complete & (~r_valid | data_ready_in);
    w_drop = w_complete & r_valid & ~data_ready_in;
  end

  // Shift in qualified bits and track the position within the frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_sync) begin
      // Discard any partial word; the sampled bit becomes bit 0.
      r_shift <= {sd_in, {(N-1){1'b0}}};
      r_cnt   <= CW'(1);
    end else if (w_sample) begin
      r_shift <= {sd_in, r_shift[N-1:1]};
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Holding register and valid flag for the consumer handshake.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      // Covers both a fresh word into an empty register and a back-to-back
      // handoff where the old word is consumed on this edge.
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr_in) begin
      r_overrun <= 1'b0;
    end
  end

  assign data_out       = r_data;
  assign data_valid_out = r_valid;
  assign overrun_out    = r_overrun;
  assign bit_cnt_out    = r_cnt;

endmodule
